// File: rtl/shifter_pkg.sv
// rtl/shifter_pkg.sv - op codes and FSM states shared by the universal shifter
package shifter_pkg;

  typedef enum logic [2:0] {
    OP_HOLD = 3'b000,
    OP_SHL  = 3'b001,
    OP_SHR  = 3'b010,
    OP_LOAD = 3'b011,
    OP_ROL  = 3'b100,
    OP_ROR  = 3'b101,
    OP_ASR  = 3'b110,
    OP_CLR  = 3'b111
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_EXEC = 2'b01,
    ST_DONE = 2'b10
  } state_e;

endpackage

// File: rtl/shifter_step.sv
// rtl/shifter_step.sv - combinational next-value datapath, shifts/rotates by amt positions
import shifter_pkg::*;

module shifter_step #(
  parameter int WIDTH = 8,
  parameter int AMT_W = $clog2(WIDTH + 1)
) (
  input  logic [WIDTH-1:0] value,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] load,
  input  logic             fill_l,
  input  logic             fill_r,
  input  logic [AMT_W-1:0] amt,
  output logic [WIDTH-1:0] next_val
);

  logic [WIDTH-1:0]        ones;
  logic [WIDTH-1:0]        shl_mask;
  logic [WIDTH-1:0]        shr_mask;
  logic signed [WIDTH-1:0] sval;
  int unsigned             rot;

  assign ones = {WIDTH{1'b1}};

  always_comb begin
    // An amt of WIDTH or more shifts everything out, leaving only fill bits.
    shl_mask = ~(ones << amt);
    shr_mask = ~(ones >> amt);
    sval     = value;
    rot      = 32'(amt) % WIDTH;
    next_val = value;
    case (op_e'(op))
      OP_HOLD: next_val = value;
      OP_SHL:  next_val = (value << amt) | ({WIDTH{fill_r}} & shl_mask);
      OP_SHR:  next_val = (value >> amt) | ({WIDTH{fill_l}} & shr_mask);
      OP_LOAD: next_val = load;
      OP_ROL:  next_val = (value << rot) | (value >> (WIDTH - rot));
      OP_ROR:  next_val = (value >> rot) | (value << (WIDTH - rot));
      OP_ASR:  next_val = sval >>> amt;
      OP_CLR:  next_val = '0;
      default: next_val = value;
    endcase
  end

endmodule

// File: rtl/universal_shifter.sv
// rtl/universal_shifter.sv - start/busy/done universal shift register
// UNIVERSAL_SHIFTER_BARREL_EN selects a single-step barrel datapath instead of bit-serial steps.
import shifter_pkg::*;

module universal_shifter #(
  parameter int WIDTH = 8,
  parameter int AMT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [AMT_W-1:0] amount,
  input  logic [WIDTH-1:0] load_data,
  input  logic             ser_in_r,
  input  logic             ser_in_l,
  output logic [WIDTH-1:0] result,
  output logic             busy,
  output logic             done,
  output logic             ser_out_l,
  output logic             ser_out_r
);

  state_e           state;
  logic [2:0]       op_q;
  logic [AMT_W-1:0] amt_q;
  logic [AMT_W-1:0] cnt;
  logic [WIDTH-1:0] load_q;
  logic             fill_l_q;
  logic             fill_r_q;
  logic [AMT_W-1:0] step_amt;
  logic [AMT_W-1:0] first_cnt;
  logic [WIDTH-1:0] next_val;

`ifdef UNIVERSAL_SHIFTER_BARREL_EN
  assign step_amt  = amt_q;
  assign first_cnt = '0;
`else
  logic single_step;

  assign single_step = (op == OP_HOLD) || (op == OP_LOAD) || (op == OP_CLR);
  // A zero-amount shift still takes one step, but that step must move nothing.
  assign step_amt    = (amt_q == '0) ? '0 : AMT_W'(1);
  assign first_cnt   = (single_step || amount == '0) ? '0 : amount - AMT_W'(1);
`endif

  shifter_step #(
    .WIDTH(WIDTH),
    .AMT_W(AMT_W)
  ) u_step (
    .value   (result),
    .op      (op_q),
    .load    (load_q),
    .fill_l  (fill_l_q),
    .fill_r  (fill_r_q),
    .amt     (step_amt),
    .next_val(next_val)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      result   <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      cnt      <= '0;
      op_q     <= 3'b000;
      amt_q    <= '0;
      load_q   <= '0;
      fill_l_q <= 1'b0;
      fill_r_q <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          done <= 1'b0;
          if (start) begin
            op_q     <= op;
            amt_q    <= amount;
            load_q   <= load_data;
            fill_l_q <= ser_in_l;
            fill_r_q <= ser_in_r;
            cnt      <= first_cnt;
            busy     <= 1'b1;
            state    <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          result <= next_val;
          if (cnt == '0) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= ST_DONE;
          end else begin
            cnt <= cnt - AMT_W'(1);
          end
        end
        ST_DONE: begin
          done  <= 1'b0;
          state <= ST_IDLE;
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

  assign ser_out_l = result[WIDTH-1];
  assign ser_out_r = result[0];

endmodule

// File: tb/tb_universal_shifter.sv
// tb/tb_universal_shifter.sv - randomized bench for universal_shifter against a bit-level model
module tb_universal_shifter;

  localparam int W  = 8;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [2:0]    op = 3'b000;
  logic [AW-1:0] amount = '0;
  logic [W-1:0]  load_data = '0;
  logic          ser_in_r = 1'b0;
  logic          ser_in_l = 1'b0;
  logic [W-1:0]  result;
  logic          busy;
  logic          done;
  logic          ser_out_l;
  logic          ser_out_r;

  int chk_cnt = 0;
  int pass_cnt = 0;

  universal_shifter #(.WIDTH(W), .AMT_W(AW)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .op       (op),
    .amount   (amount),
    .load_data(load_data),
    .ser_in_r (ser_in_r),
    .ser_in_l (ser_in_l),
    .result   (result),
    .busy     (busy),
    .done     (done),
    .ser_out_l(ser_out_l),
    .ser_out_r(ser_out_r)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] ref_op(input logic [W-1:0] v, input logic [2:0] o,
                                          input int a, input logic [W-1:0] d,
                                          input logic sl, input logic sr);
    logic [W-1:0] n;
    int r;
    r = a % W;
    n = v;
    case (o)
      3'd1: for (int i = 0; i < W; i++) n[i] = (i >= a) ? v[i-a] : sr;
      3'd2: for (int i = 0; i < W; i++) n[i] = (i + a < W) ? v[i+a] : sl;
      3'd3: n = d;
      3'd4: for (int i = 0; i < W; i++) n[(i + r) % W] = v[i];
      3'd5: for (int i = 0; i < W; i++) n[i] = v[(i + r) % W];
      3'd6: for (int i = 0; i < W; i++) n[i] = (i + a < W) ? v[i+a] : v[W-1];
      3'd7: n = '0;
      default: n = v;
    endcase
    return n;
  endfunction

  function automatic int steps_for(input logic [2:0] o, input int a);
`ifdef UNIVERSAL_SHIFTER_BARREL_EN
    return 1;
`else
    if (o == 3'd0 || o == 3'd3 || o == 3'd7) return 1;
    return (a == 0) ? 1 : a;
`endif
  endfunction

  task automatic check(input string nm, input logic [W-1:0] got, input logic [W-1:0] exp);
    chk_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
  endtask

  // Model: phase 0 idle, 1 executing with rem steps left, 2 completion cycle.
  int           m_phase = 0;
  int           m_rem = 0;
  logic [W-1:0] m_val = '0;
  logic [W-1:0] m_final = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_phase = 0;
      m_rem   = 0;
      m_val   = '0;
    end else begin
      case (m_phase)
        0: if (start) begin
          m_final = ref_op(m_val, op, int'(amount), load_data, ser_in_l, ser_in_r);
          m_rem   = steps_for(op, int'(amount));
          m_phase = 1;
        end
        1: begin
          m_rem--;
          if (m_rem == 0) begin
            m_val   = m_final;
            m_phase = 2;
          end
        end
        default: m_phase = 0;
      endcase
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      check("busy", {7'b0, busy}, {7'b0, m_phase == 1});
      check("done", {7'b0, done}, {7'b0, m_phase == 2});
      if (m_phase != 1) begin
        check("result", result, m_val);
        check("ser_out_l", {7'b0, ser_out_l}, {7'b0, m_val[W-1]});
        check("ser_out_r", {7'b0, ser_out_r}, {7'b0, m_val[0]});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic cmd(input logic [2:0] o, input int a, input logic [W-1:0] d,
                     input logic sl, input logic sr, input logic [W-1:0] exp, input string nm);
    bit got;
    start = 1'b1; op = o; amount = AW'(a); load_data = d; ser_in_l = sl; ser_in_r = sr;
    tick();
    start = 1'b0;
    op = 3'($urandom); load_data = W'($urandom); ser_in_l = 1'($urandom); ser_in_r = 1'($urandom);
    got = 0;
    for (int i = 0; i < 40 && !got; i++) begin
      tick();
      if (done) got = 1;
    end
    chk_cnt++;
    if (got) pass_cnt++;
    else $display("FAIL %s_timeout: done not seen, required within 40 cycles", nm);
    check(nm, result, exp);
    tick();
  endtask

  initial begin
    check("model_shl", ref_op(8'hA5, 3'd1, 3, 8'h00, 1'b0, 1'b1), 8'h2F);
    check("model_shr", ref_op(8'h2F, 3'd2, 2, 8'h00, 1'b0, 1'b0), 8'h0B);
    check("model_asr", ref_op(8'h96, 3'd6, 9, 8'h00, 1'b0, 1'b0), 8'hFF);
    check("model_rol", ref_op(8'h96, 3'd4, 11, 8'h00, 1'b0, 1'b0), 8'hB4);

    repeat (3) tick();
    check("rst_result", result, 8'h00);
    check("rst_busy", {7'b0, busy}, 8'h00);
    check("rst_done", {7'b0, done}, 8'h00);
    rst_n = 1'b1;
    tick();

    // Reset part-way through a multi-step shift.
    cmd(3'd3, 0, 8'hFF, 1'b0, 1'b0, 8'hFF, "load_ff");
    start = 1'b1; op = 3'd1; amount = 4'd5; ser_in_r = 1'b0;
    tick();
    start = 1'b0;
    tick();
    rst_n = 1'b0;
    #1;
    check("abort_result", result, 8'h00);
    check("abort_busy", {7'b0, busy}, 8'h00);
    check("abort_done", {7'b0, done}, 8'h00);
    tick();
    rst_n = 1'b1;
    repeat (6) tick();

    cmd(3'd3, 0, 8'hA5, 1'b0, 1'b0, 8'hA5, "load_a5");
    cmd(3'd1, 3, 8'h00, 1'b0, 1'b1, 8'h2F, "shl3");
    cmd(3'd2, 2, 8'h00, 1'b0, 1'b0, 8'h0B, "shr2");
    cmd(3'd1, 0, 8'h00, 1'b1, 1'b1, 8'h0B, "shl0");
    cmd(3'd3, 0, 8'h96, 1'b0, 1'b0, 8'h96, "load_96");
    cmd(3'd6, 9, 8'h00, 1'b0, 1'b0, 8'hFF, "asr9");
    cmd(3'd3, 0, 8'h96, 1'b0, 1'b0, 8'h96, "load_96b");
    cmd(3'd4, 11, 8'h00, 1'b0, 1'b0, 8'hB4, "rol11");
    cmd(3'd5, 8, 8'h00, 1'b0, 1'b0, 8'hB4, "ror8");
    cmd(3'd7, 3, 8'h00, 1'b0, 1'b0, 8'h00, "clr");

    // start held high: only idle-cycle accepts count, busy/done timing checked every cycle.
    start = 1'b1;
    for (int i = 0; i < 200; i++) begin
      op = 3'($urandom); amount = AW'($urandom); load_data = W'($urandom);
      ser_in_l = 1'($urandom); ser_in_r = 1'($urandom);
      tick();
    end

    for (int i = 0; i < 1500; i++) begin
      start = ($urandom_range(0, 3) == 0);
      op = 3'($urandom); amount = AW'($urandom); load_data = W'($urandom);
      ser_in_l = 1'($urandom); ser_in_r = 1'($urandom);
      tick();
    end
    start = 1'b0;
    repeat (40) tick();

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
